// File: rtl/mini_alu_exec.sv
// MiniAlu execution unit: single-cycle ALU/branch/LED ops plus an
// iterative shift-add multiplier that returns a double-width product.
package mini_alu_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_SHL  = 4'h3,
    OP_SHR  = 4'h4,
    OP_UMUL = 4'h5,
    OP_SMUL = 4'h6,
    OP_BLE  = 4'h7,
    OP_BLT  = 4'h8,
    OP_JMP  = 4'h9,
    OP_LED  = 4'hA,
    OP_STO  = 4'hB
  } op_e;
endpackage

module mini_alu_exec
  import mini_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [3:0]        iOp,
  input  logic [ADDR_W-1:0] iDest,
  input  logic [DATA_W-1:0] iSrc0,
  input  logic [DATA_W-1:0] iSrc1,
  input  logic [DATA_W-1:0] iImm,
  output logic              oWriteEnable,
  output logic [ADDR_W-1:0] oWriteAddr,
  output logic [DATA_W-1:0] oResult,
  output logic [DATA_W-1:0] oResultHi,
  output logic              oCarry,
  output logic              oBranchTaken,
  output logic [ADDR_W-1:0] oBranchTarget,
  output logic [7:0]        oLed,
  output logic              oIllegal
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0]   acc_lo_q, acc_lo_d;
  logic                sign_q, sign_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   res_hi_q, res_hi_d;
  logic                carry_q, carry_d;
  logic                br_q, br_d;
  logic [ADDR_W-1:0]   bt_q, bt_d;
  logic [7:0]          led_q, led_d;
  logic                ill_q, ill_d;

  logic                accept;
  logic                smul;
  logic                shift_oob;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     step;
  logic [DATA_W-1:0]   mag0, mag1;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    sign_d   = sign_q;
    dest_d   = dest_q;
    ready_d  = ready_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    carry_d  = 1'b0;
    br_d     = 1'b0;
    bt_d     = bt_q;
    led_d    = led_q;
    ill_d    = 1'b0;

    accept    = iValid & ready_q;
    smul      = (iOp == OP_SMUL);
    shift_oob = (32'(iSrc0) >= 32'(DATA_W));
    sum       = {1'b0, iSrc1} + {1'b0, iSrc0};
    // Most-negative input negates to itself, which is the right magnitude
    mag0 = (smul & iSrc0[DATA_W-1]) ? -iSrc0 : iSrc0;
    mag1 = (smul & iSrc1[DATA_W-1]) ? -iSrc1 : iSrc1;

    step = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, mcand_q})
                       : {1'b0, acc_hi_q};
    prod = {step, acc_lo_q[DATA_W-1:1]};

    unique case (state_q)
      S_MUL: begin
        acc_hi_d = prod[2*DATA_W-1:DATA_W];
        acc_lo_d = prod[DATA_W-1:0];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d  = S_DONE;
          ready_d  = 1'b1;
          we_d     = 1'b1;
          waddr_d  = dest_q;
          {res_hi_d, res_d} = sign_q ? -prod : prod;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          unique case (iOp)
            OP_NOP: begin
            end
            OP_ADD: begin
              res_d    = sum[DATA_W-1:0];
              carry_d  = sum[DATA_W];
              res_hi_d = '0;
              we_d     = 1'b1;
              waddr_d  = iDest;
            end
            OP_SUB: begin
              res_d    = iSrc1 - iSrc0;
              carry_d  = (iSrc1 < iSrc0);
              res_hi_d = '0;
              we_d     = 1'b1;
              waddr_d  = iDest;
            end
            OP_SHL: begin
              res_d    = shift_oob ? '0 : (iSrc1 << iSrc0);
              res_hi_d = '0;
              we_d     = 1'b1;
              waddr_d  = iDest;
            end
            OP_SHR: begin
              res_d    = shift_oob ? '0 : (iSrc1 >> iSrc0);
              res_hi_d = '0;
              we_d     = 1'b1;
              waddr_d  = iDest;
            end
            OP_UMUL, OP_SMUL: begin
              state_d  = S_MUL;
              ready_d  = 1'b0;
              cnt_d    = '0;
              mcand_d  = mag0;
              acc_lo_d = mag1;
              acc_hi_d = '0;
              sign_d   = smul & (iSrc0[DATA_W-1] ^ iSrc1[DATA_W-1]);
              dest_d   = iDest;
            end
            OP_BLE: begin
              br_d = (iSrc1 <= iSrc0);
              bt_d = iDest;
            end
            OP_BLT: begin
              br_d = ($signed(iSrc1) < $signed(iSrc0));
              bt_d = iDest;
            end
            OP_JMP: begin
              br_d = 1'b1;
              bt_d = iDest;
            end
            OP_LED: begin
              led_d = 8'(iSrc1);
            end
            OP_STO: begin
              res_d    = iImm;
              res_hi_d = '0;
              we_d     = 1'b1;
              waddr_d  = iDest;
            end
            default: begin
              ill_d = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      sign_q   <= 1'b0;
      dest_q   <= '0;
      ready_q  <= 1'b1;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      carry_q  <= 1'b0;
      br_q     <= 1'b0;
      bt_q     <= '0;
      led_q    <= '0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      sign_q   <= sign_d;
      dest_q   <= dest_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      carry_q  <= carry_d;
      br_q     <= br_d;
      bt_q     <= bt_d;
      led_q    <= led_d;
      ill_q    <= ill_d;
    end
  end

  assign oReady        = ready_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddr    = waddr_q;
  assign oResult       = res_q;
  assign oResultHi     = res_hi_q;
  assign oCarry        = carry_q;
  assign oBranchTaken  = br_q;
  assign oBranchTarget = bt_q;
  assign oLed          = led_q;
  assign oIllegal      = ill_q;

endmodule

// File: tb/tb_mini_alu_exec.sv
// Bench for mini_alu_exec: arithmetic reference model checked every
// cycle, plus directed vectors with literal expected values.
module tb_mini_alu_exec;

  localparam int W  = 16;
  localparam int AW = 8;
  localparam int PW = 2 * W;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          iValid = 1'b0;
  logic [3:0]    iOp = '0;
  logic [AW-1:0] iDest = '0;
  logic [W-1:0]  iSrc0 = '0;
  logic [W-1:0]  iSrc1 = '0;
  logic [W-1:0]  iImm = '0;
  logic          oReady;
  logic          oWriteEnable;
  logic [AW-1:0] oWriteAddr;
  logic [W-1:0]  oResult;
  logic [W-1:0]  oResultHi;
  logic          oCarry;
  logic          oBranchTaken;
  logic [AW-1:0] oBranchTarget;
  logic [7:0]    oLed;
  logic          oIllegal;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mini_alu_exec #(.DATA_W(W), .ADDR_W(AW)) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .iOp(iOp), .iDest(iDest), .iSrc0(iSrc0), .iSrc1(iSrc1),
    .iImm(iImm), .oWriteEnable(oWriteEnable), .oWriteAddr(oWriteAddr),
    .oResult(oResult), .oResultHi(oResultHi), .oCarry(oCarry),
    .oBranchTaken(oBranchTaken), .oBranchTarget(oBranchTarget),
    .oLed(oLed), .oIllegal(oIllegal)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected output registers and a busy countdown
  logic          e_ready, e_we, e_carry, e_br, e_ill;
  logic [AW-1:0] e_waddr, e_bt, m_dest;
  logic [W-1:0]  e_res, e_hi;
  logic [7:0]    e_led;
  logic [PW-1:0] m_prod;
  int            m_cnt;
  longint        u0, u1, s0, s1, sm;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      e_ready <= 1'b1; e_we <= 1'b0; e_carry <= 1'b0; e_br <= 1'b0;
      e_ill <= 1'b0; e_waddr <= '0; e_bt <= '0; e_res <= '0;
      e_hi <= '0; e_led <= '0; m_cnt <= 0; m_prod <= '0; m_dest <= '0;
    end else begin
      e_we <= 1'b0; e_br <= 1'b0; e_ill <= 1'b0; e_carry <= 1'b0;
      u0 = longint'(iSrc0);
      u1 = longint'(iSrc1);
      s0 = $signed(iSrc0);
      s1 = $signed(iSrc1);
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          e_we <= 1'b1;
          {e_hi, e_res} <= m_prod;
          e_waddr <= m_dest;
          e_ready <= 1'b1;
        end
      end else if (iValid) begin
        case (iOp)
          4'h0: ;
          4'h1: begin
            sm = u1 + u0;
            e_res <= W'(sm); e_carry <= ((sm >> W) & 1) != 0;
            e_hi <= '0; e_we <= 1'b1; e_waddr <= iDest;
          end
          4'h2: begin
            e_res <= W'(u1 - u0); e_carry <= (u1 < u0);
            e_hi <= '0; e_we <= 1'b1; e_waddr <= iDest;
          end
          4'h3: begin
            e_res <= (u0 >= W) ? '0 : W'(u1 << u0);
            e_hi <= '0; e_we <= 1'b1; e_waddr <= iDest;
          end
          4'h4: begin
            e_res <= (u0 >= W) ? '0 : W'(u1 >> u0);
            e_hi <= '0; e_we <= 1'b1; e_waddr <= iDest;
          end
          4'h5: begin
            m_prod <= PW'(u0 * u1); m_cnt <= W;
            e_ready <= 1'b0; m_dest <= iDest;
          end
          4'h6: begin
            m_prod <= PW'(s0 * s1); m_cnt <= W;
            e_ready <= 1'b0; m_dest <= iDest;
          end
          4'h7: begin e_br <= (u1 <= u0); e_bt <= iDest; end
          4'h8: begin e_br <= (s1 < s0); e_bt <= iDest; end
          4'h9: begin e_br <= 1'b1; e_bt <= iDest; end
          4'hA: e_led <= iSrc1[7:0];
          4'hB: begin
            e_res <= iImm; e_hi <= '0; e_we <= 1'b1; e_waddr <= iDest;
          end
          default: e_ill <= 1'b1;
        endcase
      end
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("m_ready", oReady, e_ready);
      chk("m_we", oWriteEnable, e_we);
      chk("m_waddr", oWriteAddr, e_waddr);
      chk("m_res", oResult, e_res);
      chk("m_hi", oResultHi, e_hi);
      chk("m_carry", oCarry, e_carry);
      chk("m_br", oBranchTaken, e_br);
      chk("m_bt", oBranchTarget, e_bt);
      chk("m_led", oLed, e_led);
      chk("m_ill", oIllegal, e_ill);
    end
  end

  task automatic send(input logic [3:0] op, input logic [AW-1:0] d,
                      input logic [W-1:0] a0, input logic [W-1:0] a1,
                      input logic [W-1:0] imm);
    @(posedge Clock); #1;
    iValid = 1'b1; iOp = op; iDest = d;
    iSrc0 = a0; iSrc1 = a1; iImm = imm;
  endtask

  // Idle cycle with a live-looking ADD on the bus that must be ignored
  task automatic idle();
    @(posedge Clock); #1;
    iValid = 1'b0; iOp = 4'h1; iSrc0 = 16'h0101; iSrc1 = 16'h0202;
  endtask

  task automatic mul_run(input logic [3:0] op, input logic [W-1:0] a0,
                         input logic [W-1:0] a1, output int low,
                         output int lat);
    send(op, 8'h33, a0, a1, '0);
    idle();
    low = 0;
    lat = -1;
    iValid = 1'b1; iOp = 4'h1; iSrc0 = 16'h1111; iSrc1 = 16'h2222;
    for (int n = 0; n < 40; n++) begin
      if (oWriteEnable) begin
        lat = n;
        break;
      end
      if (!oReady) low++;
      @(posedge Clock); #1;
    end
    iValid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, lat, pulses;
    Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk_en = 1'b1;
    chk("rst_ready", oReady, 1);
    chk("rst_res", oResult, 0);
    chk("rst_led", oLed, 0);
    chk("rst_we", oWriteEnable, 0);
    Reset = 1'b1;

    send(4'h1, 8'h05, 16'h0002, 16'hFFFF, '0);
    idle();
    chk("add_res", oResult, 16'h0001);
    chk("add_carry", oCarry, 1);
    chk("add_we", oWriteEnable, 1);
    chk("add_waddr", oWriteAddr, 8'h05);
    idle();
    chk("add_we_drop", oWriteEnable, 0);
    chk("add_carry_drop", oCarry, 0);
    chk("add_res_hold", oResult, 16'h0001);

    send(4'h2, 8'h06, 16'h0005, 16'h0002, '0);
    idle();
    chk("sub_res", oResult, 16'hFFFD);
    chk("sub_borrow", oCarry, 1);

    mul_run(4'h6, 16'hFFFD, 16'h0005, low, lat);
    chk("smul_lat", lat, 16);
    chk("smul_busy", low, 16);
    chk("smul_lo", oResult, 16'hFFF1);
    chk("smul_hi", oResultHi, 16'hFFFF);
    chk("smul_ready", oReady, 1);
    chk("smul_waddr", oWriteAddr, 8'h33);
    idle();
    chk("smul_we_drop", oWriteEnable, 0);

    mul_run(4'h5, 16'hFFFF, 16'hFFFF, low, lat);
    chk("umul_lat", lat, 16);
    chk("umul_lo", oResult, 16'h0001);
    chk("umul_hi", oResultHi, 16'hFFFE);

    mul_run(4'h6, 16'h8000, 16'h8000, low, lat);
    chk("smin_lat", lat, 16);
    chk("smin_lo", oResult, 16'h0000);
    chk("smin_hi", oResultHi, 16'h4000);

    send(4'h3, 8'h01, 16'd15, 16'h0001, '0);
    idle();
    chk("shl15", oResult, 16'h8000);
    chk("shl_hi0", oResultHi, 16'h0000);
    send(4'h3, 8'h01, 16'd16, 16'h0001, '0);
    idle();
    chk("shl16", oResult, 16'h0000);
    send(4'h4, 8'h01, 16'd15, 16'h8000, '0);
    idle();
    chk("shr15", oResult, 16'h0001);

    send(4'h7, 8'h20, 16'h0010, 16'h0010, '0);
    idle();
    chk("ble_taken", oBranchTaken, 1);
    chk("ble_target", oBranchTarget, 8'h20);
    chk("ble_nowrite", oWriteEnable, 0);
    send(4'h8, 8'h21, 16'h0001, 16'hFFFF, '0);
    idle();
    chk("blt_taken", oBranchTaken, 1);
    send(4'h7, 8'h22, 16'h0001, 16'hFFFF, '0);
    idle();
    chk("ble_not", oBranchTaken, 0);
    send(4'h9, 8'h44, 16'h0000, 16'h0000, '0);
    idle();
    chk("jmp_taken", oBranchTaken, 1);
    chk("jmp_target", oBranchTarget, 8'h44);

    send(4'h1, 8'h07, 16'h0003, 16'h0004, '0);
    send(4'hA, 8'h00, 16'h0000, 16'h00A5, '0);
    chk("b2b_add", oResult, 16'h0007);
    send(4'hD, 8'h00, 16'h0000, 16'h0000, '0);
    chk("b2b_led", oLed, 8'hA5);
    chk("b2b_led_nowe", oWriteEnable, 0);
    send(4'hB, 8'h09, 16'h0000, 16'h0000, 16'h1234);
    chk("b2b_ill", oIllegal, 1);
    idle();
    chk("b2b_sto", oResult, 16'h1234);
    chk("b2b_sto_we", oWriteEnable, 1);
    chk("b2b_ill_drop", oIllegal, 0);
    chk("b2b_led_hold", oLed, 8'hA5);

    send(4'h5, 8'h0B, 16'h0003, 16'h0004, '0);
    idle();
    repeat (4) begin
      @(posedge Clock); #1;
    end
    #2;
    Reset = 1'b0;
    #1;
    chk("abort_ready", oReady, 1);
    chk("abort_res", oResult, 0);
    chk("abort_hi", oResultHi, 0);
    chk("abort_led", oLed, 0);
    chk("abort_we", oWriteEnable, 0);
    @(posedge Clock); #1;
    iValid = 1'b1; iOp = 4'h1; iDest = 8'h0A;
    iSrc0 = 16'h0004; iSrc1 = 16'h0003;
    #3;
    Reset = 1'b1;
    @(posedge Clock); #1;
    iValid = 1'b0;
    chk("post_rst_add", oResult, 16'h0007);
    chk("post_rst_we", oWriteEnable, 1);
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge Clock); #1;
      if (oWriteEnable) pulses++;
    end
    chk("abort_nowrite", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mini_alu_exec.md
Name: mini_alu_exec

Overview:
Parametrised execution unit for the next-generation MiniAlu core. It accepts one decoded instruction per cycle over a valid/ready handshake and returns registered results to the register file, branch logic and LED latch. It adds an iterative multi-cycle signed/unsigned multiplier that produces a full double-width product. It sits between the decode FFs and the RAM write port / IP counter.

Parameters:
DATA_W, 16, operand/result width; legal range 4..32.
ADDR_W, 8, register-file address width (destination / branch target).

Ports:
Clock  in  1  single clock, rising edge.
Reset  in  1  asynchronous reset, active-low: 0 resets all state immediately.
iValid  in  1  instruction present.
oReady  out  1  unit can accept this cycle.
iOp  in  4  opcode (see Behaviour).
iDest  in  ADDR_W  destination address / branch target.
iSrc0  in  DATA_W  operand 0.
iSrc1  in  DATA_W  operand 1.
iImm  in  DATA_W  immediate for STO.
oWriteEnable  out  1  one-cycle write pulse.
oWriteAddr  out  ADDR_W  registered iDest.
oResult  out  DATA_W  result, or low half of the product.
oResultHi  out  DATA_W  high half of the product; 0 for other ops.
oCarry  out  1  ADD carry-out / SUB borrow; 0 otherwise.
oBranchTaken  out  1  one-cycle branch pulse.
oBranchTarget  out  ADDR_W  registered iDest.
oLed  out  8  LED latch.
oIllegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Accept = iValid & oReady at a rising Clock edge. Inputs are ignored otherwise.
- Reset low: FSM goes to IDLE; all outputs 0 except oReady=1; multiplier registers cleared.
- Opcodes:
  - 0 NOP.
  - 1 ADD: src1+src0.
  - 2 SUB: src1-src0.
  - 3 SHL: src1<<src0.
  - 4 SHR: logical src1>>src0.
  - 5 UMUL.
  - 6 SMUL.
  - 7 BLE: unsigned, taken if src1<=src0.
  - 8 BLT: signed, taken if src1<src0.
  - 9 JMP.
  - A LED: oLed<=src1[7:0].
  - B STO: result=iImm.
  - C..F illegal.
- Single-cycle ops (everything except 5 and 6) have 1-cycle latency. Outputs are registered and valid in the cycle after accept. oReady stays 1, so back-to-back issue runs at full rate.
- ADD, SUB, SHL, SHR and STO assert oWriteEnable for exactly one cycle.
- NOP, branches, LED and illegal opcodes assert no write.
- ADD/SUB wrap modulo 2^DATA_W. oCarry = bit DATA_W of the unsigned sum; for SUB it is the borrow (src1<src0).
- Shifts: if src0 >= DATA_W, the result is 0.
- Branch ops pulse oBranchTaken for 1 cycle when taken (JMP always taken). oBranchTarget = iDest.
- oLed holds its value until the next LED op or reset.
- oIllegal pulses for 1 cycle on opcodes C..F. No other effect.
- Pulse outputs (oWriteEnable, oBranchTaken, oIllegal, oCarry) return to 0 in the following cycle unless a new op drives them.
- oResult/oResultHi hold their last value between ops.
- Multiply FSM: IDLE -> MUL -> DONE -> IDLE.
  - On accept of op 5 or 6: latch the operands and enter MUL; oReady=0.
  - SMUL: operands are converted to magnitudes; the sign is latched as sign(src0) xor sign(src1).
  - MUL: shift-add, one multiplier bit per cycle, exactly DATA_W cycles. Counter is $clog2(DATA_W+1) bits.
  - DONE: the 2*DATA_W product is negated if the sign is set. {oResultHi,oResult}=product, oWriteEnable=1 for this one cycle; oReady returns to 1 in the same cycle.
  - Latency from accept to the write pulse is DATA_W+1 cycles. iValid is ignored while oReady=0.
- The most-negative operand (e.g. 0x8000 at DATA_W=16) must multiply correctly: a magnitude of 2^(DATA_W-1) fits unsigned.
- Reset asserted mid-multiply aborts immediately. No write pulse is produced for the aborted op. The first edge after reset release may accept a new op.

Test Plan:
- DATA_W=16: ADD 0xFFFF+0x0002, dest 0x05 -> next cycle oResult=0x0001, oCarry=1, oWriteEnable=1 for one cycle, oWriteAddr=0x05.
- SMUL src0=0xFFFD (-3), src1=0x0005 -> oReady low for 16 cycles; at cycle 17 after accept oResult=0xFFF1, oResultHi=0xFFFF, single write pulse. Repeat with UMUL 0xFFFF*0xFFFF -> Hi=0xFFFE, Lo=0x0001. Repeat with SMUL 0x8000*0x8000 -> Hi=0x4000, Lo=0x0000.
- SHL src1=0x0001, src0=15 -> 0x8000. SHL src0=16 -> 0x0000. SHR 0x8000 by 15 -> 0x0001.
- BLE src1=src0=0x0010, target 0x20 -> oBranchTaken pulse, oBranchTarget=0x20, no write. BLT src1=0xFFFF, src0=0x0001 -> taken. BLE same operands -> not taken.
- Back-to-back ADD, LED(0x00A5), opcode 0xD, STO(0x1234) on consecutive cycles -> four consecutive result cycles: oLed=0xA5 persists, oIllegal pulses once, STO writes 0x1234.
- Start UMUL, pull Reset low at cycle 5 -> all outputs 0 and oReady=1 immediately, no write pulse. After release, ADD 3+4 -> oResult=0x0007 in the next cycle.
